// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial adder, LSB first, one full-adder cell with a
// registered carry. {carryOut,sum} = opA + opB + carryIn after WIDTH shift cycles.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             sumBit
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_c, r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_cn, w_last;

  // single full-adder cell working on the operand LSBs
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cn   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic; start is only looked at in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state-decoded outputs; sumBit is a debug tap, forced low outside SHIFT
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    sumBit = 1'b0;
    case (r_state)
      S_SHIFT: begin busy = 1'b1; sumBit = w_s; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // datapath: capture on accept, shift one bit per SHIFT cycle.
  // The final carry is registered on the last shift edge so carryOut is
  // already valid in the DONE cycle (it equals the carry flop from then on).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= opA;
          r_b   <= opB;
          r_c   <= carryIn;
          r_sum <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_cout <= w_cn;
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign carryOut = r_cout;

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // signed overflow: carry out of the MSB xor carry into the MSB (r_c on the last shift)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_ovf <= 1'b0;
    else if (r_state == S_SHIFT && w_last) r_ovf <= w_cn ^ r_c;
  end

  assign overflow = r_ovf;
`endif

endmodule
